axi_cfg_master: RTL and testbench
=================================

AXI_CFG_MASTER -- requirements
Module: axi_cfg_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI-Lite data width; strobe width is C_M_AXI_DATA_WIDTH/8.
REQ-003 SHALL have port s_axi_aclk, input, 1: clock.
REQ-004 SHALL have port s_axi_aresetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1: command handshake.
REQ-006 SHALL have ports cmd_we_i in 1 (1=write), cmd_addr_i in ADDR, cmd_wdata_i in DATA, cmd_wstrb_i in DATA/8: command payload.
REQ-007 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-008 SHALL have ports rsp_rdata_o out DATA, rsp_err_o out 1 (BRESP/RRESP not OKAY), rsp_mismatch_o out 1 (verify compare failed).
REQ-009 SHALL have AXI-Lite master write ports: m_axi_awaddr/awvalid out, awready in; m_axi_wdata/wstrb/wvalid out, wready in; m_axi_bresp[1:0]/bvalid in, bready out.
REQ-010 SHALL have AXI-Lite master read ports: m_axi_araddr/arvalid out, arready in; m_axi_rdata/rresp[1:0]/rvalid in, rready out.

Function
REQ-011 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, VF_ADDR, VF_DATA, RESP.
REQ-012 SHALL assert cmd_ready_o only in IDLE; on cmd_valid_i&&cmd_ready_o latch all payload and go to WR_ADDR_DATA (we=1) or RD_ADDR (we=0).
REQ-013 SHALL in WR_ADDR_DATA drive awvalid and wvalid together from the next cycle after acceptance; each drops independently the cycle after its own handshake; go to WR_RESP once both have completed (same or different cycles).
REQ-014 SHALL hold awaddr/wdata/wstrb/araddr stable while the corresponding valid is high (AXI rule: valid never drops before ready).
REQ-015 SHALL assert bready only in WR_RESP; on bvalid capture err=(bresp!=2'b00), then go to VF_ADDR (verify enabled, err=0) or RESP.
REQ-016 SHALL in RD_ADDR/VF_ADDR assert arvalid with the latched address until arready; then RD_DATA/VF_DATA with rready=1 until rvalid.
REQ-017 SHALL in RD_DATA capture rdata into rsp_rdata_o and err=(rresp!=2'b00); go to RESP.
REQ-018 SHALL in RESP assert rsp_valid_o with stable rsp_* until rsp_ready_i; then return to IDLE; rsp_* undefined-but-stable outside RESP is not allowed: hold last values.
REQ-019 SHALL issue at most one AXI transaction outstanding; never assert arvalid and awvalid simultaneously.
REQ-020 SHALL, with an always-ready slave and rsp_ready_i=1, return rsp_valid_o for a read no earlier than 3 cycles after command acceptance.
REQ-021 SHALL ignore bvalid/rvalid arriving outside WR_RESP/RD_DATA/VF_DATA (no ready asserted).
REQ-022 SHALL clear rsp_mismatch_o for every read command and for writes with verify disabled.

Reset
REQ-023 SHALL on reset assertion go to IDLE immediately, aborting any in-flight transaction; all valid/ready outputs 0 except cmd_ready_o=1 after deassertion; rsp_rdata_o=0, rsp_err_o=0, rsp_mismatch_o=0, all m_axi address/data/strobe outputs 0.

Configuration
REQ-024 SHALL compile write read-back verify in with macro AXI_CFG_MASTER_VERIFY_EN: after an OKAY write, read the same address, compare rdata against wdata masked per-byte by wstrb, set rsp_mismatch_o on any difference, report rdata on rsp_rdata_o, OR rresp error into rsp_err_o.
REQ-025 SHALL without AXI_CFG_MASTER_VERIFY_EN omit VF_ADDR/VF_DATA and compare logic; writes go WR_RESP->RESP, rsp_mismatch_o tied 0.

Structure
REQ-026 SHALL place state enum, AXI response encodings (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) in shared package axi_cfg_pkg.
REQ-027 SHALL have no sub-modules; single FSM plus capture registers.

Verification
REQ-028 Write addr 0x04 data 0x1234_5678 strb 0xF, slave awready before wready by 2 cycles -> one AW, one W handshake, rsp_valid_o, err=0.
REQ-029 Read addr 0x08, slave returns rdata 0xDEAD_BEEF rresp 0 after 5-cycle arready stall -> arvalid held 5 cycles, rsp_rdata_o=0xDEAD_BEEF, err=0.
REQ-030 Write with bresp=2'b10 -> rsp_err_o=1, no verify read issued.
REQ-031 VERIFY_EN: write 0xAABB_CCDD strb 0x3, readback 0x1111_CCDD -> mismatch=0; readback 0x1111_CCDE -> mismatch=1.
REQ-032 rsp_ready_i low 4 cycles -> rsp_* stable, cmd_ready_o=0, no new AXI activity.
REQ-033 Reset asserted while awvalid high -> all valids 0 same edge, cmd_ready_o=1 after release, next command completes normally.

Source files
------------

// File: rtl/axi_cfg_pkg.sv
// Shared definitions for the AXI-Lite configuration master.
// Holds the FSM state encoding and the AXI response codes.
package axi_cfg_pkg;

   // Master FSM states; VF_* are reached only when the
   // AXI_CFG_MASTER_VERIFY_EN build option is defined.
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WR_ADDR_DATA = 3'd1,
      WR_RESP      = 3'd2,
      RD_ADDR      = 3'd3,
      RD_DATA      = 3'd4,
      VF_ADDR      = 3'd5,
      VF_DATA      = 3'd6,
      RESP         = 3'd7
   } state_e;

   // AXI BRESP/RRESP encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Anything other than OKAY is reported as an error to the requester.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/axi_cfg_master.sv
// AXI-Lite configuration master.
// Accepts one command at a time on a valid/ready interface, performs a single
// AXI-Lite write or read, and returns the outcome on a valid/ready response.
// Build option AXI_CFG_MASTER_VERIFY_EN: after an OKAY write, read the same
// address back and flag any difference in the strobed bytes.
// Ports:
//   s_axi_aclk, s_axi_aresetn      clock, async active-low reset
//   cmd_*                          command in (we, addr, wdata, wstrb)
//   rsp_*                          response out (rdata, err, mismatch)
//   m_axi_aw*/w*/b*                AXI-Lite write channels
//   m_axi_ar*/r*                   AXI-Lite read channels
module axi_cfg_master
   import axi_cfg_pkg::*;
#(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                              s_axi_aclk,
   input  logic                              s_axi_aresetn,
   // command
   input  logic                              cmd_valid_i,
   output logic                              cmd_ready_o,
   input  logic                              cmd_we_i,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata_i,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb_i,
   // response
   output logic                              rsp_valid_o,
   input  logic                              rsp_ready_i,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata_o,
   output logic                              rsp_err_o,
   output logic                              rsp_mismatch_o,
   // AXI-Lite write
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   input  logic [1:0]                        m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,
   // AXI-Lite read
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic                              m_axi_arvalid,
   input  logic                              m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                        m_axi_rresp,
   input  logic                              m_axi_rvalid,
   output logic                              m_axi_rready
);

   localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
   localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

   state_e          state_q, state_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            awvalid_q, awvalid_d;
   logic            wvalid_q, wvalid_d;
   logic            bready_q, bready_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;

`ifdef AXI_CFG_MASTER_VERIFY_EN
   logic            mismatch_q, mismatch_d;
   logic [DW-1:0]   wmask;

   // Byte-enable mask of the write being verified.
   always_comb begin
      wmask = '0;
      for (int unsigned b = 0; b < SW; b++) begin
         wmask[b*8 +: 8] = {8{wstrb_q[b]}};
      end
   end
`endif

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
`ifdef AXI_CFG_MASTER_VERIFY_EN
      mismatch_d  = mismatch_q;
`endif

      case (state_q)
         IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               addr_d      = cmd_addr_i;
               wdata_d     = cmd_wdata_i;
               wstrb_d     = cmd_wstrb_i;
               if (cmd_we_i) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_ADDR_DATA;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end

         // AW and W complete independently; a channel whose valid is already
         // low has finished its handshake.
         WR_ADDR_DATA: begin
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
            if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end

         // rsp_* only change on the way into RESP so they hold otherwise.
         WR_RESP: begin
            if (m_axi_bvalid && bready_q) begin
               bready_d = 1'b0;
`ifdef AXI_CFG_MASTER_VERIFY_EN
               if (!resp_is_err(m_axi_bresp)) begin
                  arvalid_d = 1'b1;
                  state_d   = VF_ADDR;
               end else begin
                  err_d       = 1'b1;
                  mismatch_d  = 1'b0;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end
`else
               err_d       = resp_is_err(m_axi_bresp);
               rsp_valid_d = 1'b1;
               state_d     = RESP;
`endif
            end
         end

         RD_ADDR: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end

         RD_DATA: begin
            if (m_axi_rvalid && rready_q) begin
               rready_d    = 1'b0;
               rdata_d     = m_axi_rdata;
               err_d       = resp_is_err(m_axi_rresp);
`ifdef AXI_CFG_MASTER_VERIFY_EN
               mismatch_d  = 1'b0;
`endif
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end

`ifdef AXI_CFG_MASTER_VERIFY_EN
         VF_ADDR: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = VF_DATA;
            end
         end

         // Write was OKAY, so the read response alone decides rsp_err.
         VF_DATA: begin
            if (m_axi_rvalid && rready_q) begin
               rready_d    = 1'b0;
               rdata_d     = m_axi_rdata;
               err_d       = resp_is_err(m_axi_rresp);
               mismatch_d  = |((m_axi_rdata ^ wdata_q) & wmask);
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
`endif

         RESP: begin
            if (rsp_valid_q && rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

`ifdef AXI_CFG_MASTER_VERIFY_EN
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) mismatch_q <= 1'b0;
      else                mismatch_q <= mismatch_d;
   end
   assign rsp_mismatch_o = mismatch_q;
`else
   assign rsp_mismatch_o = 1'b0;
`endif

   // One address register serves both channels; only one is ever valid.
   assign cmd_ready_o   = cmd_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rdata_q;
   assign rsp_err_o     = err_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_cfg_master.sv
// Directed self-checking bench for axi_cfg_master with a small AXI-Lite
// slave model whose ready delays and responses are set per test.
module tb_axi_cfg_master;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_mm;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   always #5 clk = ~clk;

   axi_cfg_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rstn),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_mismatch_o(rsp_mm),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   // ---------------- slave model ----------------
   int          aw_dly = 0, w_dly = 0, ar_dly = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [DW-1:0] rdata_cfg = '0;

   int aw_hi, w_hi, ar_hi;
   logic aw_got, w_got, ar_got;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, ar_cyc = 0, both_err = 0, stab_err = 0;
   logic aw_pend, w_pend, ar_pend;
   logic [AW-1:0] aw_prev, ar_prev;
   logic [DW-1:0] w_prev;

   assign awready = awvalid && (aw_hi >= aw_dly);
   assign wready  = wvalid  && (w_hi  >= w_dly);
   assign arready = arvalid && (ar_hi >= ar_dly);

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_hi <= 0; w_hi <= 0; ar_hi <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
         aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
         aw_prev <= '0; w_prev <= '0; ar_prev <= '0;
      end else begin
         aw_hi <= (awvalid && !awready) ? aw_hi + 1 : 0;
         w_hi  <= (wvalid  && !wready)  ? w_hi  + 1 : 0;
         ar_hi <= (arvalid && !arready) ? ar_hi + 1 : 0;
         if (arvalid) ar_cyc <= ar_cyc + 1;
         if (awvalid && arvalid) both_err <= both_err + 1;
         // valid must not drop and payload must not move while stalled
         if (aw_pend && (!awvalid || awaddr != aw_prev)) stab_err <= stab_err + 1;
         if (w_pend  && (!wvalid  || wdata  != w_prev))  stab_err <= stab_err + 1;
         if (ar_pend && (!arvalid || araddr != ar_prev)) stab_err <= stab_err + 1;
         aw_pend <= awvalid && !awready; aw_prev <= awaddr;
         w_pend  <= wvalid  && !wready;  w_prev  <= wdata;
         ar_pend <= arvalid && !arready; ar_prev <= araddr;
         if (bvalid && bready) bvalid <= 1'b0;
         else if (!bvalid && aw_got && w_got) begin
            bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (rvalid && rready) rvalid <= 1'b0;
         else if (!rvalid && ar_got) begin
            rvalid <= 1'b1; rdata <= rdata_cfg; rresp <= rresp_cfg; ar_got <= 1'b0;
         end
         if (awvalid && awready) begin aw_cnt <= aw_cnt + 1; aw_got <= 1'b1; end
         if (wvalid && wready)   begin w_cnt  <= w_cnt + 1;  w_got  <= 1'b1; end
         if (arvalid && arready) begin ar_cnt <= ar_cnt + 1; ar_got <= 1'b1; end
      end
   end

   // ---------------- checking ----------------
   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   logic [DW-1:0] g_rdata;
   logic          g_err, g_mm;
   int            lat;

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // lat = posedges after the accepting edge before rsp_valid is seen
   task automatic wait_rsp();
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      g_rdata = rsp_rdata; g_err = rsp_err; g_mm = rsp_mm;
      @(posedge clk); #1;
   endtask

   int aw0, w0, ar0, cyc0;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_awvalid", 64'(awvalid), 0);
      chk("rst_arvalid", 64'(arvalid), 0);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 1);
      chk("rst_rdata", 64'(rsp_rdata), 0);
      chk("rst_err", 64'(rsp_err), 0);
      chk("rst_mm", 64'(rsp_mm), 0);
      chk("rst_awaddr", 64'(awaddr), 0);
      chk("rst_wdata", 64'(wdata), 0);
      chk("rst_wstrb", 64'(wstrb), 0);
      chk("rst_bready", 64'(bready), 0);
      chk("rst_rready", 64'(rready), 0);

      // write, W accepted two cycles after AW
      aw_dly = 0; w_dly = 2; rdata_cfg = 32'h1234_5678;
      aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
      send(1'b1, 32'h04, 32'h1234_5678, 4'hF);
      wait_rsp();
      chk("wr_aw_cnt", 64'(aw_cnt - aw0), 1);
      chk("wr_w_cnt", 64'(w_cnt - w0), 1);
      chk("wr_err", 64'(g_err), 0);
      chk("wr_mm", 64'(g_mm), 0);
`ifdef AXI_CFG_MASTER_VERIFY_EN
      chk("wr_vf_ar_cnt", 64'(ar_cnt - ar0), 1);
`else
      chk("wr_ar_cnt", 64'(ar_cnt - ar0), 0);
`endif

      // read with arready stalled 5 cycles: arvalid seen at 6 edges
      w_dly = 0; ar_dly = 5; rdata_cfg = 32'hDEAD_BEEF;
      cyc0 = ar_cyc;
      send(1'b0, 32'h08, 32'h0, 4'h0);
      wait_rsp();
      chk("rd_ar_cycles", 64'(ar_cyc - cyc0), 6);
      chk("rd_rdata", 64'(g_rdata), 64'hDEAD_BEEF);
      chk("rd_err", 64'(g_err), 0);
      chk("rd_mm", 64'(g_mm), 0);

      // minimal read latency with always-ready slave (>= 3 cycles)
      ar_dly = 0; rdata_cfg = 32'h0000_00A5;
      send(1'b0, 32'h0C, 32'h0, 4'h0);
      wait_rsp();
      chk("rd_latency", 64'(lat), 3);
      chk("rd_rdata2", 64'(g_rdata), 64'hA5);

      // read with SLVERR on rresp
      rresp_cfg = 2'b10; rdata_cfg = 32'h0BAD_0BAD;
      send(1'b0, 32'h14, 32'h0, 4'h0);
      wait_rsp();
      chk("rd_rresp_err", 64'(g_err), 1);
      rresp_cfg = 2'b00;

      // write with SLVERR: error reported, no verify read
      bresp_cfg = 2'b10;
      ar0 = ar_cnt;
      send(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
      wait_rsp();
      chk("wr_bresp_err", 64'(g_err), 1);
      chk("wr_err_no_ar", 64'(ar_cnt - ar0), 0);
      chk("wr_err_mm", 64'(g_mm), 0);
      chk("wr_err_rdata_hold", 64'(g_rdata), 64'h0BAD_0BAD);
      bresp_cfg = 2'b00;

`ifdef AXI_CFG_MASTER_VERIFY_EN
      // only bytes 0..1 are compared (strb 0x3)
      rdata_cfg = 32'h1111_CCDD;
      send(1'b1, 32'h30, 32'hAABB_CCDD, 4'h3);
      wait_rsp();
      chk("vf_match_mm", 64'(g_mm), 0);
      chk("vf_match_rdata", 64'(g_rdata), 64'h1111_CCDD);
      chk("vf_match_err", 64'(g_err), 0);
      rdata_cfg = 32'h1111_CCDE;
      send(1'b1, 32'h30, 32'hAABB_CCDD, 4'h3);
      wait_rsp();
      chk("vf_diff_mm", 64'(g_mm), 1);
      chk("vf_diff_rdata", 64'(g_rdata), 64'h1111_CCDE);
      rresp_cfg = 2'b11; rdata_cfg = 32'hAABB_CCDD;
      send(1'b1, 32'h34, 32'hAABB_CCDD, 4'hF);
      wait_rsp();
      chk("vf_rresp_err", 64'(g_err), 1);
      rresp_cfg = 2'b00;
      // a following read clears mismatch
      rdata_cfg = 32'h1111_CCDE;
      send(1'b1, 32'h30, 32'hAABB_CCDD, 4'h3);
      wait_rsp();
      send(1'b0, 32'h30, 32'h0, 4'h0);
      wait_rsp();
      chk("vf_rd_clears_mm", 64'(g_mm), 0);
`endif

      // response back-pressure: everything holds for 4 cycles
      rsp_ready = 1'b0; rdata_cfg = 32'h7654_3210;
      send(1'b0, 32'h40, 32'h0, 4'h0);
      wait_rsp();
      aw0 = aw_cnt; ar0 = ar_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 64'(rsp_valid), 1);
         chk("hold_rdata", 64'(rsp_rdata), 64'h7654_3210);
         chk("hold_cmd_ready", 64'(cmd_ready), 0);
      end
      chk("hold_no_axi", 64'((aw_cnt - aw0) + (ar_cnt - ar0)), 0);
      chk("hold_no_arvalid", 64'(arvalid | awvalid), 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_valid", 64'(rsp_valid), 0);
      chk("hold_release_ready", 64'(cmd_ready), 1);
      chk("hold_after_rdata", 64'(rsp_rdata), 64'h7654_3210);

      // reset in the middle of a stalled write
      aw_dly = 20;
      send(1'b1, 32'h50, 32'h0F0F_0F0F, 4'hF);
      @(negedge clk);
      chk("mid_awvalid", 64'(awvalid), 1);
      #2 rstn = 1'b0;
      #1;
      chk("arst_awvalid", 64'(awvalid), 0);
      chk("arst_wvalid", 64'(wvalid), 0);
      chk("arst_bready", 64'(bready), 0);
      chk("arst_rdata", 64'(rsp_rdata), 0);
      chk("arst_awaddr", 64'(awaddr), 0);
      @(negedge clk);
      rstn = 1'b1;
      aw_dly = 0;
      @(negedge clk);
      chk("arst_cmd_ready", 64'(cmd_ready), 1);
      rdata_cfg = 32'h5555_AAAA;
      send(1'b0, 32'h10, 32'h0, 4'h0);
      wait_rsp();
      chk("post_rst_rdata", 64'(g_rdata), 64'h5555_AAAA);
      chk("post_rst_err", 64'(g_err), 0);

      // idle: no ready toward the slave
      @(negedge clk);
      chk("idle_bready", 64'(bready), 0);
      chk("idle_rready", 64'(rready), 0);
      chk("never_aw_and_ar", 64'(both_err), 0);
      chk("payload_stable", 64'(stab_err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
